// File: rtl/pipelined_shift_add_mult.sv
// pipelined_shift_add_mult: valid/ready shift-and-add multiplier with a registered adder tree.
// Partial products are stored in one flat array: level k begins at 2N-(2N>>k).
module pipelined_shift_add_mult #(
  parameter int A_W = 16,
  parameter int B_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     A,
  input  logic [B_W-1:0]     B,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] outProduct
);
  localparam int P_W = A_W + B_W;
  localparam int LAT = 1 + $clog2(B_W);
  localparam int LVL = LAT - 1;
  localparam int N   = 1 << LVL;
  localparam int T   = 2 * N - 1;
  logic           w_adv;
  logic [P_W-1:0] w_ax;
  logic [P_W-1:0] w_nx [T];
  logic [P_W-1:0] r_t  [T];
  logic [LVL:0]   r_v;
  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv;
  assign w_ax      = {{B_W{in_signed & A[A_W-1]}}, A};
  assign out_valid = r_v[LVL];
  assign outProduct = r_t[T-1];
  // The top multiplier bit carries negative weight in two's complement mode.
  always_comb begin
    w_nx = r_t;
    for (int i = 0; i < N; i++) w_nx[i] = '0;
    for (int i = 0; i < B_W - 1; i++) w_nx[i] = B[i] ? (w_ax << i) : '0;
    w_nx[B_W-1] = B[B_W-1] ? (in_signed ? -(w_ax << (B_W-1)) : (w_ax << (B_W-1))) : '0;
    for (int k = 1; k <= LVL; k++)
      for (int j = 0; j < (N >> k); j++)
        w_nx[2*N - ((2*N) >> k) + j] = r_t[2*N - ((4*N) >> k) + 2*j] + r_t[2*N - ((4*N) >> k) + 2*j + 1];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_v <= '0;
      r_t <= '{default: '0};
    end else if (w_adv) begin
      r_v <= {r_v[LVL-1:0], in_valid};
      r_t <= w_nx;
    end
endmodule

// File: tb/tb_pipelined_shift_add_mult.sv
// tb_pipelined_shift_add_mult: directed and random checks against a product-level pipeline model.
module tb_pipelined_shift_add_mult;
  logic        clk = 0;
  logic        reset = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [3:0]  B = '0;
  logic        in_signed = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [19:0] outProduct;
  int          n_vec = 0;
  int          n_err = 0;
  logic [2:0]  m_v = '0;
  logic [19:0] m_p [3];
  logic [19:0] got [$];
  logic [19:0] held;
  int          n_acc;

  pipelined_shift_add_mult dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .outProduct(outProduct)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [3:0] b, input logic s);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[19:0];
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc(input logic v, input logic [15:0] a, input logic [3:0] b, input logic s, input logic ordy);
    logic adv;
    in_valid = v; A = a; B = b; in_signed = s; out_ready = ordy;
    #1;
    adv = !m_v[2] || ordy;
    chk("in_ready", in_ready, adv);
    if (out_valid && ordy) got.push_back(outProduct);
    if (v && adv) n_acc++;
    @(posedge clk);
    if (adv) begin
      m_p[2] = m_p[1];
      m_p[1] = m_p[0];
      m_p[0] = ref_mul(a, b, s);
      m_v = {m_v[1:0], v};
    end
    @(negedge clk);
    chk("out_valid", out_valid, m_v[2]);
    if (m_v[2]) chk("product", outProduct, m_p[2]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, 1);
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [3:0] b, input logic s, input logic [19:0] exp);
    cyc(1, a, b, s, 1);
    idle(1);
    chk({tag, "_early"}, out_valid, 0);
    idle(1);
    chk({tag, "_lat"}, out_valid, 1);
    chk(tag, outProduct, exp);
    idle(1);
  endtask

  initial begin
    m_p[0] = '0; m_p[1] = '0; m_p[2] = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_prod", outProduct, 0);
    chk("rst_ready", in_ready, 1);
    reset = 0;
    @(negedge clk);

    directed("uns_max", 16'hFFFF, 4'hF, 0, 20'h0EFFF1);
    directed("sgn_m1", 16'hFFFF, 4'hF, 1, 20'h00001);
    directed("sgn_min", 16'h8000, 4'h8, 1, 20'h40000);
    directed("sgn_mix", 16'h0003, 4'hE, 1, 20'hFFFFA);

    got.delete();
    for (int i = 0; i < 8; i++) cyc(1, 16'(i), 4'(i), 0, 1);
    idle(3);
    chk("tput_cnt", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("tput_val", got[i], i * i);

    got.delete();
    n_acc = 0;
    for (int i = 0; i < 3; i++) cyc(1, 16'(100 + i), 4'(i + 3), 0, 1);
    held = outProduct;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'h1234, 4'h5, 0, 0);
      chk("bp_ready", in_ready, 0);
      chk("bp_hold", outProduct, held);
    end
    idle(5);
    chk("bp_cnt", got.size(), n_acc);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("bp_order", got[i], ref_mul(16'(100 + i), 4'(i + 3), 0));

    for (int i = 0; i < 3; i++) cyc(1, 16'hABCD, 4'(i + 9), 1, 1);
    reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_prod", outProduct, 0);
    m_v = '0;
    @(negedge clk);
    reset = 0;
    got.delete();
    idle(4);
    chk("post_rst_none", got.size(), 0);

    got.delete();
    n_acc = 0;
    for (int i = 0; i < 10000; i++)
      cyc(($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    idle(4);
    chk("rnd_cnt", got.size(), n_acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
